// File: rtl/mem_access_if.sv
// Request/response and data-memory bundle for the MEM-stage load/store unit.
// The master side is the pipeline plus memory; the slave side is mem_access_unit.
// Direction and reset behaviour are defined by the unit. The interface is wires only.
interface mem_access_if #(
  parameter int WORD_LEN = 32
);
  // pipeline request
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [WORD_LEN-1:0] req_addr;
  logic [WORD_LEN-1:0] req_wdata;
  // completion
  logic                rsp_valid;
  logic [WORD_LEN-1:0] rsp_rdata;
  logic [1:0]          rsp_fault;
  // word-indexed data memory
  logic                mem_write_en;
  logic                mem_read_en;
  logic [WORD_LEN-1:0] mem_address;
  logic [WORD_LEN-1:0] mem_data_in;
  logic [WORD_LEN-1:0] mem_data_out;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_write_en, mem_read_en, mem_address, mem_data_in
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_write_en, mem_read_en, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end: byte/half/word requests to word memory accesses, with RMW for sub-word stores.
// Latency to rsp_valid after accept: fault 1, word store 2, load 3, sub-word store 4 cycles.
// One request in flight; req_ready only in IDLE, so a held request waits until the unit is free.
module mem_access_unit #(
  parameter int WORD_LEN  = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,   // asynchronous, active low
  mem_access_if.slave bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] F_OK    = 2'b00;
  localparam logic [1:0] F_ALIGN = 2'b01;
  localparam logic [1:0] F_RANGE = 2'b10;
  localparam logic [1:0] F_SIZE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic                we_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [WORD_LEN-1:0] addr_q;
  logic [WORD_LEN-1:0] word_q;   // store word, or merged word for a sub-word store

  logic                accept;
  logic [1:0]          fault_now;

  // Replace only the addressed lane(s) of the old word; untouched bytes survive exactly.
  function automatic logic [WORD_LEN-1:0] merge_lane(
    input logic [WORD_LEN-1:0] old_word,
    input logic [WORD_LEN-1:0] wdata,
    input logic [1:0]          size,
    input logic [1:0]          off
  );
    logic [WORD_LEN-1:0] m;
    m = old_word;
    case (size)
      SZ_BYTE: m[{off, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: m[{off[1], 4'b0000} +: 16]   = wdata[15:0];
      default: m                            = wdata;
    endcase
    return m;
  endfunction

  // Shift the addressed lane down to bit 0 and extend it.
  function automatic logic [WORD_LEN-1:0] extract_lane(
    input logic [WORD_LEN-1:0] raw,
    input logic [1:0]          size,
    input logic                sgn,
    input logic [1:0]          off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [WORD_LEN-1:0] r;
    b = raw[{off, 3'b000} +: 8];
    h = raw[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = sgn ? {{(WORD_LEN-8){b[7]}}, b}   : {{(WORD_LEN-8){1'b0}}, b};
      SZ_HALF: r = sgn ? {{(WORD_LEN-16){h[15]}}, h} : {{(WORD_LEN-16){1'b0}}, h};
      default: r = raw;
    endcase
    return r;
  endfunction

  // Fault classification of the incoming request, highest priority first.
  always_comb begin
    fault_now = F_OK;
    if (bus.req_size == F_SIZE) begin
      fault_now = F_SIZE;
    end else if ((bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                 (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)) begin
      fault_now = F_ALIGN;
    end else if ({2'b00, bus.req_addr[WORD_LEN-1:2]} >= WORD_LEN'(MEM_WORDS)) begin
      fault_now = F_RANGE;
    end
  end

  assign accept = bus.req_valid && bus.req_ready;

  // State register; reset abandons any access in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection and state-decoded handshake/memory outputs.
  always_comb begin
    state_nxt        = state;
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_address  = '0;
    bus.mem_data_in  = '0;
    case (state)
      S_IDLE: begin
        bus.req_ready = reset;
        if (accept) begin
          if (fault_now != F_OK)                          state_nxt = S_RESP;
          else if (bus.req_we && bus.req_size == SZ_WORD) state_nxt = S_WRITE;
          else                                            state_nxt = S_READ;
        end
      end
      S_READ: begin
        bus.mem_read_en = 1'b1;
        bus.mem_address = {2'b00, addr_q[WORD_LEN-1:2]};
        state_nxt       = S_WAIT;
      end
      S_WAIT: begin
        state_nxt = we_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        bus.mem_write_en = 1'b1;
        bus.mem_address  = {2'b00, addr_q[WORD_LEN-1:2]};
        bus.mem_data_in  = word_q;
        state_nxt        = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, RMW merge and registered response payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      addr_q        <= '0;
      word_q        <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_fault <= F_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q     <= bus.req_we;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            addr_q   <= bus.req_addr;
            word_q   <= bus.req_wdata;
            if (fault_now != F_OK) begin
              bus.rsp_rdata <= '0;
              bus.rsp_fault <= fault_now;
            end
          end
        end
        S_WAIT: begin
          if (we_q) begin
            word_q <= merge_lane(bus.mem_data_out, word_q, size_q, addr_q[1:0]);
          end else begin
            bus.rsp_rdata <= extract_lane(bus.mem_data_out, size_q, signed_q, addr_q[1:0]);
            bus.rsp_fault <= F_OK;
          end
        end
        S_WRITE: begin
          bus.rsp_rdata <= '0;
          bus.rsp_fault <= F_OK;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a behavioural word memory.
// Table of single requests with hand-computed latency/data/fault, then back-to-back and reset sequences.
// Memory model answers read_en with data on the following cycle, like DATA_OUT_REG.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_if #(.WORD_LEN(32)) bus ();

  mem_access_unit #(.WORD_LEN(32), .MEM_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // behavioural data memory
  logic [31:0] mem [1024];
  logic [31:0] mem_dout = 32'h0;
  assign bus.mem_data_out = mem_dout;

  int rd_cnt = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;

  always @(posedge clk) begin
    if (bus.mem_read_en)  mem_dout <= mem[bus.mem_address[9:0]];
    if (bus.mem_write_en) mem[bus.mem_address[9:0]] <= bus.mem_data_in;
    if (bus.mem_read_en)  rd_cnt <= rd_cnt + 1;
    if (bus.mem_write_en) wr_cnt <= wr_cnt + 1;
    if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
    if (bus.rsp_valid)    rsp_cnt <= rsp_cnt + 1;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic [1:0]  fault;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req_we     = v.we;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
  endtask

  // One request: wait for ready, hold valid for one edge, time the response.
  task automatic do_req(input vec_t v, input string tag);
    int n, t, rd0, wr0, exp_rd, exp_wr;
    @(negedge clk);
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " ready"}, bus.req_ready, 1);
    drive(v);
    bus.req_valid = 1'b1;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp_rd = (v.lat >= 3) ? 1 : 0;
    exp_wr = (v.lat == 2 || v.lat == 4) ? 1 : 0;
    chk({tag, " latency"}, n, v.lat);
    chk({tag, " rdata"}, bus.rsp_rdata, v.rdata);
    chk({tag, " fault"}, {30'd0, bus.rsp_fault}, {30'd0, v.fault});
    chk({tag, " rd_pulses"}, rd_cnt - rd0, exp_rd);
    chk({tag, " wr_pulses"}, wr_cnt - wr0, exp_wr);
  endtask

  vec_t vecs[21];
  vec_t seq[4];
  logic [31:0] rsp_data[4];

  initial begin
    //            we    size   sgn   addr          wdata         lat rdata         fault
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 2, 32'h0,        2'd0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        3, 32'hDEADBEEF, 2'd0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0000_00AA, 4, 32'h0,       2'd0};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'h0,        3, 32'hFFFFFFAA, 2'd0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0011, 32'h0,        3, 32'h000000AA, 2'd0};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        3, 32'hDEADAAEF, 2'd0};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h0000_1234, 4, 32'h0,       2'd0};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        3, 32'h1234AAEF, 2'd0};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,        3, 32'hFFFFAAEF, 2'd0};
    vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,        3, 32'h00001234, 2'd0};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h0000_0013, 32'h0,        1, 32'h0,        2'd1};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h0000_1001, 32'h0,        1, 32'h0,        2'd1};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0,        1, 32'h0,        2'd2};
    vecs[13] = '{1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h12345678, 1, 32'h0,        2'd3};
    vecs[14] = '{1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'hFFFFFF55, 4, 32'h0,        2'd0};
    vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        3, 32'h5534AAEF, 2'd0};
    vecs[16] = '{1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,        3, 32'h00005534, 2'd0};
    vecs[17] = '{1'b0, 2'd0, 1'b1, 32'h0000_0010, 32'h0,        3, 32'hFFFFFFEF, 2'd0};
    vecs[18] = '{1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'h01020304, 2, 32'h0,        2'd0};
    vecs[19] = '{1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0,        3, 32'h01020304, 2'd0};
    vecs[20] = '{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,        3, 32'h0,        2'd0};

    seq[0] = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0, 32'h0, 2'd0};
    seq[1] = '{1'b0, 2'd0, 1'b0, 32'h21, 32'h0,        0, 32'h0, 2'd0};
    seq[2] = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 0, 32'h0, 2'd0};
    seq[3] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        0, 32'h0, 2'd0};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst req_ready", bus.req_ready, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst rsp_rdata", bus.rsp_rdata, 0);
    chk("rst rsp_fault", {30'd0, bus.rsp_fault}, 0);
    chk("rst mem_en", {bus.mem_read_en, bus.mem_write_en}, 0);
    chk("rst mem_address", bus.mem_address, 0);
    chk("rst mem_data_in", bus.mem_data_in, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post-rst req_ready", bus.req_ready, 1);

    // single-request table
    for (int i = 0; i < 21; i++) do_req(vecs[i], $sformatf("v%0d", i));

    // valid held high across four mixed requests
    begin
      int a0, r0, k, r, viol;
      @(negedge clk);
      a0 = acc_cnt;
      r0 = rsp_cnt;
      k = 0;
      r = 0;
      viol = 0;
      drive(seq[0]);
      bus.req_valid = 1'b1;
      for (int c = 0; c < 80 && r < 4; c++) begin
        @(negedge clk);
        if (acc_cnt - a0 != k) begin
          k = acc_cnt - a0;
          if (k >= 4) bus.req_valid = 1'b0;
          else        drive(seq[k]);
        end
        if (bus.rsp_valid) begin
          rsp_data[r] = bus.rsp_rdata;
          r++;
        end
        if ((acc_cnt - a0) > (rsp_cnt - r0) && bus.req_ready) viol++;
      end
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b accepts", acc_cnt - a0, 4);
      chk("b2b responses", rsp_cnt - r0, 4);
      chk("b2b ready_busy", viol, 0);
      chk("b2b byte load", rsp_data[1], 32'h00000033);
      chk("b2b word load", rsp_data[3], 32'hBEEF3344);
    end

    // reset while a byte store sits in WAIT
    begin
      int wr0;
      vec_t v;
      v = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h77, 0, 32'h0, 2'd0};
      @(negedge clk);
      drive(v);
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("rmw read_en", bus.mem_read_en, 1);
      @(negedge clk);
      wr0 = wr_cnt;
      reset = 1'b0;
      #1;
      chk("mid-rst outputs", {bus.req_ready, bus.rsp_valid, bus.mem_read_en, bus.mem_write_en}, 0);
      chk("mid-rst mem_address", bus.mem_address, 0);
      chk("mid-rst mem_data_in", bus.mem_data_in, 0);
      chk("mid-rst rsp_rdata", bus.rsp_rdata, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      chk("mid-rst no write", wr_cnt - wr0, 0);
      v = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, 32'h5534AAEF, 2'd0};
      do_req(v, "post-rst reread");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
